// File: rtl/eth_rx_fcs_check.sv
// Ethernet receive FCS checker.
// Registers the raw GMII RX stream, strips preamble/SFD, checks the FCS with
// the CRC-32 residue method and forwards the payload with the FCS removed.
// Per-frame status holds until the next frame_done.
// Optional feature macro: RX_STAT_CNT_EN enables the good/bad frame counters;
// when it is undefined, good_cnt and bad_cnt are tied to zero.
module eth_rx_fcs_check #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  input  logic [7:0]  gmii_rxd,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic        frame_done,
  output logic        frame_good,
  output logic        crc_err,
  output logic        len_err,
  output logic [10:0] frame_len,
  output logic [31:0] good_cnt,
  output logic [31:0] bad_cnt
);

  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
  localparam logic [10:0] MIN_L       = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L       = 11'(MAX_LEN);
  localparam logic [10:0] LEN_SAT     = '1;
  localparam logic [10:0] PIPE_DEPTH  = 11'd5;

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  state_t          state, state_nxt;
  logic            dv_q, er_q;
  logic [7:0]      rxd_q;
  logic [2:0]      pre_cnt;
  logic [31:0]     crc, crc_nxt;
  logic [10:0]     byte_cnt;
  logic            er_flag;
  logic [4:0][7:0] pipe;
  logic            sfd_hit, accept, end_hit;
  logic            has_payload, crc_bad, len_bad, good_w;

  // Serial CRC step: byte bits enter LSB first into an MSB-first shift register
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int unsigned i = 0; i < 8; i++) begin
      fb = r[31] ^ d[i];
      r  = {r[30:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    end
    return r;
  endfunction

  assign crc_nxt     = crc_step(crc, rxd_q);
  assign has_payload = (byte_cnt >= PIPE_DEPTH);
  assign crc_bad     = (crc != CRC_RESIDUE);
  assign len_bad     = (byte_cnt < MIN_L) || (byte_cnt > MAX_L);
  assign good_w      = !crc_bad && !len_bad && !er_flag;

  // Input stage: register the GMII pins once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_q  <= 1'b0;
      er_q  <= 1'b0;
      rxd_q <= '0;
    end else begin
      dv_q  <= gmii_rx_dv;
      er_q  <= gmii_rx_er;
      rxd_q <= gmii_rxd;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state and per-cycle datapath strobes
  always_comb begin
    state_nxt = state;
    sfd_hit   = 1'b0;
    accept    = 1'b0;
    end_hit   = 1'b0;
    unique case (state)
      IDLE: begin
        if (dv_q) state_nxt = (rxd_q == 8'h55) ? PREAMBLE : DROP;
      end
      PREAMBLE: begin
        if (!dv_q) begin
          state_nxt = IDLE;
        end else if (rxd_q == 8'h55) begin
          if (pre_cnt == 3'd7) state_nxt = DROP;
        end else if (rxd_q == 8'hD5) begin
          state_nxt = DATA;
          sfd_hit   = 1'b1;
        end else begin
          state_nxt = DROP;
        end
      end
      DATA: begin
        if (dv_q) begin
          accept = 1'b1;
        end else begin
          end_hit   = 1'b1;
          state_nxt = IDLE;
        end
      end
      DROP: begin
        if (!dv_q) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Preamble 0x55 counter; entering PREAMBLE always starts at one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= 3'd1;
    end else if (state == IDLE) begin
      pre_cnt <= 3'd1;
    end else if (state == PREAMBLE && dv_q && rxd_q == 8'h55) begin
      pre_cnt <= pre_cnt + 3'd1;
    end
  end

  // Frame datapath: CRC, byte count, sticky error and the 5-byte FCS hold-back pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc      <= '1;
      byte_cnt <= '0;
      er_flag  <= 1'b0;
      pipe     <= '0;
    end else if (sfd_hit) begin
      crc      <= '1;
      byte_cnt <= '0;
      er_flag  <= 1'b0;
    end else if (accept) begin
      crc      <= crc_nxt;
      byte_cnt <= (byte_cnt == LEN_SAT) ? byte_cnt : byte_cnt + 11'd1;
      er_flag  <= er_flag | er_q;
      pipe     <= {pipe[3:0], rxd_q};
    end
  end

  // Output register: payload strobe, eof/frame_done pulse and held status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      rx_sof     <= 1'b0;
      rx_eof     <= 1'b0;
      frame_done <= 1'b0;
      frame_good <= 1'b0;
      crc_err    <= 1'b0;
      len_err    <= 1'b0;
      frame_len  <= '0;
    end else begin
      rx_valid   <= 1'b0;
      rx_sof     <= 1'b0;
      rx_eof     <= 1'b0;
      frame_done <= 1'b0;
      // pipe[4] is always the byte five positions behind the newest accepted one
      if ((accept || end_hit) && has_payload) begin
        rx_valid <= 1'b1;
        rx_data  <= pipe[4];
        rx_sof   <= (byte_cnt == PIPE_DEPTH);
        rx_eof   <= end_hit;
      end
      if (end_hit) begin
        frame_done <= 1'b1;
        frame_good <= good_w;
        crc_err    <= crc_bad;
        len_err    <= len_bad;
        frame_len  <= byte_cnt;
      end
    end
  end

`ifdef RX_STAT_CNT_EN
  // Frame counters, updated on the same edge that raises frame_done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else if (end_hit) begin
      if (good_w) good_cnt <= good_cnt + 32'd1;
      else        bad_cnt  <= bad_cnt + 32'd1;
    end
  end
`else
  assign good_cnt = '0;
  assign bad_cnt  = '0;
`endif

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Testbench for eth_rx_fcs_check: directed frames, reference CRC computed in the
// reflected (LSB-first table-free) form, per-cycle compare against expected queues.
module tb_eth_rx_fcs_check;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        gmii_rx_dv = 1'b0;
  logic        gmii_rx_er = 1'b0;
  logic [7:0]  gmii_rxd = '0;
  logic        rx_valid, rx_sof, rx_eof, frame_done, frame_good, crc_err, len_err;
  logic [7:0]  rx_data;
  logic [10:0] frame_len;
  logic [31:0] good_cnt, bad_cnt;

  eth_rx_fcs_check #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
    .clk(clk), .rst_n(rst_n),
    .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er), .gmii_rxd(gmii_rxd),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_sof(rx_sof), .rx_eof(rx_eof),
    .frame_done(frame_done), .frame_good(frame_good), .crc_err(crc_err),
    .len_err(len_err), .frame_len(frame_len), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
  );

  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    bit         sof;
    bit         eof;
    int         at;
  } pl_t;

  typedef struct {
    int          at;
    bit          has_pl;
    bit          good;
    bit          cerr;
    bit          lerr;
    logic [10:0] flen;
    logic [31:0] gc;
    logic [31:0] bc;
  } st_t;

  pl_t pq[$];
  st_t sq[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  good_m = 0;
  int  bad_m = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Standard reflected Ethernet CRC-32 (what the transmitter appends, little-endian)
  function automatic logic [31:0] model_crc(input logic [7:0] b[$], input int n);
    logic [31:0] c;
    c = '1;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, b[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic make_frame(input int total, input int seed, output logic [7:0] f[$]);
    logic [31:0] c;
    f.delete();
    for (int i = 0; i < total - 4; i++) f.push_back(8'(i + seed));
    c = model_crc(f, total - 4);
    f.push_back(c[7:0]);
    f.push_back(c[15:8]);
    f.push_back(c[23:16]);
    f.push_back(c[31:24]);
  endtask

  task automatic drive(input logic dv, input logic [7:0] d, input logic er);
    gmii_rx_dv = dv;
    gmii_rxd   = d;
    gmii_rx_er = er;
    @(posedge clk);
    #1;
  endtask

  // Sends preamble+SFD+frame and one dv=0 cycle, queuing what the DUT must produce.
  // abort_at >= 0 asserts reset just before that byte and discards the frame.
  task automatic send_frame(input logic [7:0] f[$], input int pre_n, input int er_idx,
                            input int abort_at);
    int L;
    int k;
    bit crc_ok, lbad, erf;
    pl_t p;
    st_t s;
    L = f.size();
    for (int i = 0; i < pre_n; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int n = 0; n < L; n++) begin
      if (n == abort_at) begin
        rst_n = 1'b0;
        pq.delete();
        sq.delete();
        good_m = 0;
        bad_m = 0;
        gmii_rx_dv = 1'b0;
        gmii_rx_er = 1'b0;
        gmii_rxd = '0;
        return;
      end
      k = cyc;
      if (n >= 5) begin
        p.data = f[n-5]; p.sof = (n == 5); p.eof = 1'b0; p.at = k + 2;
        pq.push_back(p);
      end
      drive(1'b1, f[n], 1'(n == er_idx));
    end
    k = cyc;
    if (L >= 5) begin
      p.data = f[L-5]; p.sof = (L == 5); p.eof = 1'b1; p.at = k + 2;
      pq.push_back(p);
    end
    crc_ok = (L >= 4) && (model_crc(f, L - 4) == {f[L-1], f[L-2], f[L-3], f[L-4]});
    lbad   = (L < 64) || (L > 1518);
    erf    = (er_idx >= 0) && (er_idx < L);
    s.at     = k + 2;
    s.has_pl = (L >= 5);
    s.cerr   = !crc_ok;
    s.lerr   = lbad;
    s.good   = crc_ok && !lbad && !erf;
    s.flen   = (L > 2047) ? 11'd2047 : 11'(L);
    if (s.good) good_m++;
    else        bad_m++;
`ifdef RX_STAT_CNT_EN
    s.gc = 32'(good_m);
    s.bc = 32'(bad_m);
`else
    s.gc = '0;
    s.bc = '0;
`endif
    sq.push_back(s);
    drive(1'b0, 8'h00, 1'b0);
  endtask

  // Per-cycle compare of DUT outputs against the expected queues
  always @(negedge clk) begin
    bit ev, ed;
    if (!rst_n) begin
      chk("reset_outputs", 64'({rx_valid, rx_sof, rx_eof, frame_done, frame_good,
                                crc_err, len_err, rx_data, frame_len}), 64'd0);
      chk("reset_counters", {good_cnt, bad_cnt}, 64'd0);
    end else begin
      ev = (pq.size() > 0) && (pq[0].at == cyc);
      chk("rx_valid", 64'(rx_valid), 64'(ev));
      if (ev) begin
        if (rx_valid) begin
          chk("rx_data", 64'(rx_data), 64'(pq[0].data));
          chk("rx_sof", 64'(rx_sof), 64'(pq[0].sof));
          chk("rx_eof", 64'(rx_eof), 64'(pq[0].eof));
        end
        void'(pq.pop_front());
      end
      ed = (sq.size() > 0) && (sq[0].at == cyc);
      chk("frame_done", 64'(frame_done), 64'(ed));
      if (ed) begin
        if (frame_done) begin
          chk("eof_with_done", 64'(rx_valid && rx_eof), 64'(sq[0].has_pl));
          chk("frame_good", 64'(frame_good), 64'(sq[0].good));
          chk("crc_err", 64'(crc_err), 64'(sq[0].cerr));
          chk("len_err", 64'(len_err), 64'(sq[0].lerr));
          chk("frame_len", 64'(frame_len), 64'(sq[0].flen));
          chk("good_cnt", 64'(good_cnt), 64'(sq[0].gc));
          chk("bad_cnt", 64'(bad_cnt), 64'(sq[0].bc));
        end
        void'(sq.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish, expected end of stimulus");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] f[$];
    logic [7:0] ref9[$];
    logic [31:0] exp_gc;

    // Pin the reference CRC to the published check value
    ref9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    chk("model_crc_check", 64'(model_crc(ref9, 9)), 64'h00000000CBF43926);

    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b0);

    // Good 64-byte frame, payload 0x00..0x3B
    make_frame(64, 0, f);
    send_frame(f, 7, -1, -1);
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    chk("lit_frame_len_64", 64'(frame_len), 64'd64);
    chk("lit_frame_good", 64'(frame_good), 64'd1);
    chk("lit_crc_err", 64'(crc_err), 64'd0);
`ifdef RX_STAT_CNT_EN
    exp_gc = 32'd1;
`else
    exp_gc = 32'd0;
`endif
    chk("lit_good_cnt", 64'(good_cnt), 64'(exp_gc));

    // Corrupted FCS byte 0
    f[60] = f[60] ^ 8'h01;
    send_frame(f, 7, -1, -1);

    // Runt, oversize and maximum-length frames, back to back with 1-cycle gaps
    make_frame(40, 3, f);
    send_frame(f, 7, -1, -1);
    make_frame(1519, 9, f);
    send_frame(f, 7, -1, -1);
    make_frame(1518, 11, f);
    send_frame(f, 7, -1, -1);

    // Bad preamble, then a good frame after one idle cycle
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'h12, 1'b0);
    for (int i = 0; i < 50; i++) drive(1'b1, 8'(i), 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    make_frame(64, 7, f);
    send_frame(f, 7, -1, -1);

    // gmii_rx_er on byte 20 of an otherwise good frame
    make_frame(64, 21, f);
    send_frame(f, 7, 20, -1);

    // Eight 0x55 bytes must drop the frame; then a single-0x55 preamble frame
    for (int i = 0; i < 8; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, 8'(i), 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    make_frame(64, 40, f);
    send_frame(f, 1, -1, -1);

    // Three-byte frame (no payload) and five-byte frame (single sof+eof byte)
    f = '{8'h01, 8'h02, 8'h03};
    send_frame(f, 7, -1, -1);
    make_frame(5, 100, f);
    send_frame(f, 7, -1, -1);

    // Reset at byte 30, then a good frame
    make_frame(64, 50, f);
    send_frame(f, 7, -1, 30);
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    chk("post_reset_status", 64'({frame_good, crc_err, len_err, frame_len}), 64'd0);
    make_frame(64, 60, f);
    send_frame(f, 7, -1, -1);
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    chk("lit_good_after_reset", 64'(frame_good), 64'd1);
    chk("lit_good_cnt_after_reset", 64'(good_cnt), 64'(exp_gc));

    repeat (4) drive(1'b0, 8'h00, 1'b0);
    chk("pending_payload", 64'(pq.size()), 64'd0);
    chk("pending_status", 64'(sq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/eth_rx_fcs_check.md
# eth_rx_fcs_check

Ethernet receive-side frame checker, paired with the CRC32 generator on the transmit path. Consumes the raw GMII receive byte stream, strips preamble/SFD, and verifies the FCS using the CRC-32 residue method (polynomial 0x04C11DB7). Forwards the payload with the 4 FCS bytes removed and reports per-frame status. Sits between the GMII RX pins and the UDP/ARP parser.

## Interface
- MIN_LEN, 64: minimum legal frame length in bytes, DA through FCS inclusive.
- MAX_LEN, 1518: maximum legal frame length in bytes, DA through FCS inclusive.
- clk  input  1  GMII RX clock (125 MHz); all logic is on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- gmii_rx_dv  input  1  receive data valid.
- gmii_rx_er  input  1  receive error.
- gmii_rxd  input  8  receive byte.
- rx_valid  output  1  payload byte strobe.
- rx_data  output  8  payload byte (FCS excluded).
- rx_sof  output  1  first payload byte; qualified by rx_valid.
- rx_eof  output  1  last payload byte; qualified by rx_valid.
- frame_done  output  1  1-cycle pulse; frame status fields below are valid.
- frame_good  output  1  CRC ok, length ok, no gmii_rx_er.
- crc_err  output  1  residue mismatch.
- len_err  output  1  length < MIN_LEN or > MAX_LEN.
- frame_len  output  11  byte count after SFD, including FCS; saturates at 2047.
- good_cnt  output  32  count of good frames.
- bad_cnt  output  32  count of bad frames.

## Operation
- Input stage: gmii_* registered once (1 cycle) before all processing.
- FSM states: IDLE, PREAMBLE, DATA, DROP.
- IDLE -> PREAMBLE when dv=1 and byte=0x55. Any other byte with dv=1 -> DROP.
- PREAMBLE:
  - 0x55 stays, up to 7 bytes; an 8th 0x55 -> DROP.
  - 0xD5 after at least 1 0x55 -> DATA.
  - Any other byte -> DROP.
  - dv=0 -> IDLE, with no output and no frame_done.
- DROP -> IDLE on dv=0. No output and no status.
- DATA:
  - Each byte with dv=1 updates the CRC register, increments frame_len, and enters a 5-deep byte pipe.
  - Sets a sticky er_flag if gmii_rx_er=1.
  - dv=0 -> end of frame, then IDLE.
- CRC register:
  - Preset to 0xFFFFFFFF on SFD.
  - Data bits are fed LSB-first, i.e. the byte is bit-reversed before the parallel update, MSB-first register update.
  - After the FCS bytes pass through, a correct frame leaves exactly 0xC704DD7B; any other value sets crc_err.
- Payload forwarding: when byte n (0-based after SFD, n≥5) is accepted, byte n-5 is emitted. rx_sof=1 on byte 0.
- End of frame:
  - If frame_len≥5, the byte at pipe position len-5 is emitted with rx_eof=1.
  - If frame_len<5, no payload is emitted.
  - frame_done pulses in the same cycle as the eof byte (or alone if no payload).
- frame_good = !crc_err & !len_err & !er_flag. Status outputs hold until the next frame_done.
- Frame lengths of exactly MIN_LEN and exactly MAX_LEN are legal.

## Timing
- Reset values: state IDLE; rx_valid, rx_sof, rx_eof, frame_done, frame_good, crc_err, len_err = 0; rx_data = 0; frame_len = 0; counters = 0; CRC register = 0xFFFFFFFF.
- Latency: byte n on gmii_rxd at edge t appears on rx_data at edge t+2 relative to the arrival of byte n+5.
  - 1 cycle input register plus 1 cycle output register.
- End-of-frame latency: the eof byte and frame_done appear 2 cycles after the first sample with dv=0.
- Back-to-back frames: a 1-cycle dv=0 gap is sufficient. The new frame's preamble is accepted while the previous frame_done is being issued.
- dv dropping mid-frame is normal termination (runt → len_err).
- Asynchronous reset mid-frame: all state is cleared immediately and the partial frame is discarded without a frame_done.

## Configuration
- RX_STAT_CNT_EN defined:
  - good_cnt increments on frame_done with frame_good=1.
  - bad_cnt increments on frame_done with frame_good=0.
  - Both wrap at 2^32.
- RX_STAT_CNT_EN undefined: both counters are absent and good_cnt/bad_cnt are tied to 0.

## Test plan
- Good frame: 7×0x55, 0xD5, 60 bytes 0x00..0x3B, then a correct FCS from the TX generator model. Required: 60 rx_valid bytes 0x00..0x3B, sof on 0x00, eof on 0x3B, frame_done with frame_good=1, frame_len=64, good_cnt=1.
- Same frame with FCS byte 0 XOR 0x01. Required: payload forwarded unchanged, crc_err=1, frame_good=0, bad_cnt=1.
- Runt and oversize frames: 40-byte frame with valid FCS gives len_err=1, frame_len=40. 1519-byte frame with valid FCS gives len_err=1, frame_len=1519. Exactly 1518 bytes gives frame_good=1.
- Bad preamble: 3×0x55, 0x12, 50 bytes. Required: no rx_valid and no frame_done. The next good frame after a 1-cycle gap is received correctly.
- gmii_rx_er pulsed for 1 cycle on byte 20 of an otherwise good 64-byte frame. Required: crc_err=0, frame_good=0.
- Reset asserted at byte 30 of a frame, then released, then a good frame is sent. Required: no frame_done for the aborted frame, outputs at reset values, the following frame is good with good_cnt=1.
